// File: rtl/mram_pkg.sv
// Shared types and helpers for the MRAM device emulator: FSM states, strobe
// decode, bus width defaults and the byte-lane mask.
package mram_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ_WAIT,
      ST_READ_VALID
   } state_e;

   typedef enum logic [1:0] {
      CMD_NOP,
      CMD_WRITE,
      CMD_READ,
      CMD_CONFLICT
   } cmd_e;

   // Active-low lane enables to a 16-bit data mask (bit 0 = lane [7:0]).
   function automatic logic [15:0] lane_mask(input logic lower_n, input logic upper_n);
      return {{8{~upper_n}}, {8{~lower_n}}};
   endfunction

endpackage

// File: rtl/mram_array.sv
// Word array split into independent byte lanes; each lane has a synchronous
// write and a registered, enabled read. Contents are never reset.
module mram_array
   import mram_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic [IDX_W-1:0]    waddr_i,
   input  logic [DATA_W/8-1:0] we_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                re_i,
   input  logic [IDX_W-1:0]    raddr_i,
   output logic [DATA_W-1:0]   rdata_o
);

   localparam int LANES = DATA_W / 8;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk) begin
            if (we_i[gi]) begin
               mem[waddr_i] <= wdata_i[gi*8 +: 8];
            end
         end

         always_ff @(posedge clk) begin
            if (re_i) begin
               rd_q <= mem[raddr_i];
            end
         end

         assign rdata_o[gi*8 +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/mram_responder.sv
// MRAM chip emulator: decodes the active-low strobes, writes byte lanes,
// returns reads after READ_LATENCY edges and flags protocol/range errors.
module mram_responder
   import mram_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MEM_DEPTH    = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              chip_en,
   input  logic              write_en,
   input  logic              out_en,
   input  logic              lower_byte_en,
   input  logic              upper_byte_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_valid,
   output logic              conflict_err,
   output logic              range_err
);

   localparam int         IDX_W  = $clog2(MEM_DEPTH);
   localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

   cmd_e                cmd;
   logic                oor;
   logic [IDX_W-1:0]    idx;
   logic [1:0]          lanes;
   logic                same_req;
   logic                start;
   logic                load;
   logic [DATA_W/8-1:0] wr_en;
   logic [DATA_W-1:0]   rdata;

   state_e              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [1:0]          req_lanes_q, req_lanes_d;
   logic                valid_q, valid_d;
   logic                out_ok_q, out_ok_d;
   logic [DATA_W-1:0]   out_mask_q, out_mask_d;
   logic                conf_q, conf_d;
   logic                range_q, range_d;

   assign idx   = addr[IDX_W-1:0];
   assign lanes = {upper_byte_en, lower_byte_en};

   generate
      if (IDX_W < ADDR_W) begin : g_range
         assign oor = |addr[ADDR_W-1:IDX_W];
      end else begin : g_full
         assign oor = 1'b0;
      end
   endgenerate

   always_comb begin
      cmd = CMD_NOP;
      if (!chip_en && !(lower_byte_en && upper_byte_en)) begin
         unique case ({write_en, out_en})
            2'b00:   cmd = CMD_CONFLICT;
            2'b01:   cmd = CMD_WRITE;
            2'b10:   cmd = CMD_READ;
            default: cmd = CMD_NOP;
         endcase
      end
   end

   assign same_req = (addr == req_addr_q) && (lanes == req_lanes_q);
   assign wr_en    = (cmd == CMD_WRITE && !oor) ? ~lanes : '0;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_addr_d  = req_addr_q;
      req_lanes_d = req_lanes_q;
      valid_d     = valid_q;
      out_ok_d    = out_ok_q;
      out_mask_d  = out_mask_q;
      start       = 1'b0;
      load        = 1'b0;
      conf_d      = conf_q | (cmd == CMD_CONFLICT);
      range_d     = range_q | (oor && (cmd == CMD_WRITE || cmd == CMD_READ));

      // Anything other than a read ends or aborts the current read.
      if (cmd != CMD_READ) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         cnt_d   = 3'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: start = 1'b1;
            ST_READ_WAIT: begin
               if (!same_req) begin
                  start = 1'b1;
               end else begin
                  cnt_d = cnt_q - 3'd1;
                  if (cnt_q == 3'd1) begin
                     load    = 1'b1;
                     state_d = ST_READ_VALID;
                  end
               end
            end
            ST_READ_VALID: start = !same_req;
            default: start = 1'b1;
         endcase

         if (start) begin
            req_addr_d  = addr;
            req_lanes_d = lanes;
            cnt_d       = LAT_M1;
            valid_d     = 1'b0;
            if (LAT_M1 == 3'd0) begin
               load    = 1'b1;
               state_d = ST_READ_VALID;
            end else begin
               state_d = ST_READ_WAIT;
            end
         end
      end

      // Out-of-range reads still complete, but present zero.
      if (load) begin
         valid_d    = 1'b1;
         out_ok_d   = !oor;
         out_mask_d = lane_mask(lower_byte_en, upper_byte_en);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         req_addr_q  <= '0;
         req_lanes_q <= 2'b11;
         valid_q     <= 1'b0;
         out_ok_q    <= 1'b0;
         out_mask_q  <= '0;
         conf_q      <= 1'b0;
         range_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_addr_q  <= req_addr_d;
         req_lanes_q <= req_lanes_d;
         valid_q     <= valid_d;
         out_ok_q    <= out_ok_d;
         out_mask_q  <= out_mask_d;
         conf_q      <= conf_d;
         range_q     <= range_d;
      end
   end

   mram_array #(
      .DEPTH  (MEM_DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .waddr_i (idx),
      .we_i    (wr_en),
      .wdata_i (data_in),
      .re_i    (load),
      .raddr_i (idx),
      .rdata_o (rdata)
   );

   assign data_out       = out_ok_q ? (rdata & out_mask_q) : '0;
   assign data_out_valid = valid_q;
   assign conflict_err   = conf_q;
   assign range_err      = range_q;

endmodule

// File: doc/mram_responder.md
# mram_responder

Synthesizable MRAM device emulator that sits at the far end of the FPGA-to-MRAM parallel bus, standing in for the physical chip in simulation and on-board loopback builds. It samples the active-low strobes (`chip_en`, `write_en`, `out_en`, `lower_byte_en`, `upper_byte_en`) together with a 20-bit address and 16-bit data bus. It performs byte-lane writes into an internal array and returns read data after a configurable latency. It also flags illegal strobe combinations and out-of-range addresses so the bench can check the initiator's protocol.

## Interface
- `ADDR_W`, 20: address bus width.
- `DATA_W`, 16: data bus width; two 8-bit lanes.
- `MEM_DEPTH`, 1024: implemented words; power of two, 2..2^ADDR_W.
- `READ_LATENCY`, 1: edges from strobe sampling to `data_out_valid`; legal range 1..7.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `chip_en`  in  1  chip select, active low.
- `write_en`  in  1  write strobe, active low.
- `out_en`  in  1  output/read strobe, active low.
- `lower_byte_en`  in  1  lane [7:0] enable, active low.
- `upper_byte_en`  in  1  lane [15:8] enable, active low.
- `addr`  in  ADDR_W  word address.
- `data_in`  in  DATA_W  write data from initiator.
- `data_out`  out  DATA_W  read data to initiator; disabled lanes read 0.
- `data_out_valid`  out  1  `data_out` holds valid read data.
- `conflict_err`  out  1  sticky; `write_en` and `out_en` were both low under `chip_en` low.
- `range_err`  out  1  sticky; an access addressed a word at or above `MEM_DEPTH`.

## Operation
- All inputs are sampled on the rising edge of `clk`. A cycle is active when `chip_en` is 0 and at least one lane enable is 0; otherwise it is a nop.
- Index is `addr[log2(MEM_DEPTH)-1:0]`. A nonzero upper address set makes the access out of range:
  - any access is suppressed;
  - `range_err` is set;
  - a suppressed read still completes, with `data_out` = 0.
- Write (`write_en`=0, `out_en`=1):
  - each enabled lane of `data_in` is written at that edge;
  - disabled lanes are untouched;
  - allowed from any state; a write during READ_WAIT aborts the read, and state goes to IDLE.
- Conflict (both strobes 0): no write, no read, `conflict_err` is set, and state goes to IDLE with `data_out_valid` = 0.
- Read (`out_en`=0, `write_en`=1): the address and lane enables are captured into the request registers.
- FSM states:
  - IDLE: a read request loads latency counter = READ_LATENCY-1. If the counter is 0, go to READ_VALID; else go to READ_WAIT.
  - READ_WAIT: decrement each edge. At 0, load `data_out` from the array with captured lanes masked, set `data_out_valid`, and go to READ_VALID. Strobes deasserting here abort to IDLE.
  - READ_VALID: hold `data_out` while the read strobes stay asserted with the same address and lanes.
    - A changed address or lanes restarts the request (same rule as IDLE).
    - Deassertion, a nop, or a write goes to IDLE; `data_out_valid` clears on that edge and `data_out` keeps its last value.
- Read-after-write: a write at edge N is visible to a read request sampled at edge N+1 or later.
- Reset:
  - `data_out`=0, `data_out_valid`=0, `conflict_err`=0, `range_err`=0;
  - FSM=IDLE, latency counter=0;
  - array contents are NOT cleared; reset mid-read discards the read.

## Timing
- Read latency: strobes sampled at edge E. `data_out`/`data_out_valid` update at edge E+READ_LATENCY-1, so they are visible in the cycle after that edge. With the default of 1, data is visible the cycle after the strobes are first sampled.
- Write takes effect at the sampling edge. There is no write acknowledge.
- Error flags set at the sampling edge and stay high until `rst`.
- `data_out_valid` drops exactly one edge after a read strobe deasserts.

## Structure
- Package `mram_pkg` holds:
  - the state enum (IDLE, READ_WAIT, READ_VALID);
  - `ADDR_W`/`DATA_W` defaults;
  - the lane mask function (active-low enables to 16-bit mask);
  - a strobe decode enum (NOP, WRITE, READ, CONFLICT).
- Sub-module `mram_array`: MEM_DEPTH x DATA_W, synchronous byte-lane write, synchronous read port. No reset.
- Top contains the strobe decode, FSM, latency counter, request registers and error flags.

## Test plan
- Write 0xA5C3 to addr 0x00010 with both lanes, then read the same address with both lanes -> `data_out`=0xA5C3, valid READ_LATENCY edges after sampling.
- Write 0x1234 with both lanes, write 0xFF00 to the upper lane only, then read the lower lane only -> 0x0034; read both lanes -> 0xFF34.
- `write_en`=0 and `out_en`=0 with `chip_en`=0 -> `conflict_err`=1, array unchanged, `data_out_valid`=0.
- Read addr 0x00400 with MEM_DEPTH=1024 -> `range_err`=1, `data_out`=0. A write to 0x00400 does not alias to 0x00000.
- READ_LATENCY=4: assert read, deassert after 2 cycles -> valid never rises. Re-assert for 5 cycles -> valid on the 4th edge.
- Assert `rst` during READ_VALID -> `data_out`=0, valid=0, flags=0. A subsequent read returns the pre-reset contents.
